shift_seq_ctrl: RTL and testbench
=================================

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the data width in bits.
REQ-002 SHALL have parameter AMT_W, default $clog2(WIDTH) (5), giving the shift-amount width; the legal range is 0..WIDTH-1.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port clr  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  controller can accept a request.
REQ-007 SHALL have port req_data  input  WIDTH  operand.
REQ-008 SHALL have port req_amt  input  AMT_W  shift amount in bits.
REQ-009 SHALL have port req_dir  input  1  direction: 0 = left, 1 = right.
REQ-010 SHALL have port req_arith  input  1  right-shift fill: 1 = copy MSB, 0 = zero; ignored for left shifts.
REQ-011 SHALL have port abort  input  1  synchronous cancel of the operation in flight.
REQ-012 SHALL have port res_valid  output  1  result present.
REQ-013 SHALL have port res_ready  input  1  consumer takes the result.
REQ-014 SHALL have port res_data  output  WIDTH  shifted result.
REQ-015 SHALL have port busy  output  1  high whenever state != IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-017 SHALL drive req_ready high only in IDLE with clr high; low in SHIFT and DONE.
REQ-018 SHALL accept a request on a rising edge where req_valid && req_ready, capturing req_data into the datapath and capturing req_amt, req_dir and req_arith.
REQ-019 SHALL transition IDLE->SHIFT on accept when req_amt != 0, loading the down-counter with req_amt.
REQ-020 SHALL transition IDLE->DONE on accept when req_amt == 0, leaving the data unchanged.
REQ-021 SHALL, in SHIFT, shift the datapath by exactly one bit per clock and decrement the counter by one per clock.
REQ-022 SHALL transition SHIFT->DONE on the edge that performs the final (counter==1) shift.
REQ-023 SHALL fill vacated bits as follows: left shift fills 0 at the LSB; right shift fills 0 at the MSB when req_arith=0 and the captured MSB when req_arith=1.
REQ-024 SHALL meet this latency: for a request accepted at edge k, res_valid is high after edge k+amt (amt=0 gives res_valid after edge k).
REQ-025 SHALL, in DONE, hold res_valid=1 and res_data stable until res_valid && res_ready, then transition DONE->IDLE on that edge.
REQ-026 SHALL NOT accept a new request in the cycle a result is taken; req_ready rises in the following cycle.
REQ-027 SHALL, when abort is sampled high in SHIFT or DONE, return to IDLE on that edge, clear res_valid, and produce no result.
REQ-028 SHALL ignore abort in IDLE; with abort and req_valid both high in IDLE, the request is accepted.
REQ-029 SHALL give abort priority over res_ready in DONE; the result is discarded.
REQ-030 SHALL drive res_data with the datapath register contents at all times, so the value is only meaningful while res_valid=1.

Reset
REQ-031 SHALL, while clr is low and asynchronously, force: state=IDLE, counter=0, datapath/res_data=0, res_valid=0, busy=0, req_ready=0.
REQ-032 SHALL discard any operation in flight when clr is asserted mid-operation; no result is presented after release.
REQ-033 SHALL assert req_ready in the first cycle after clr deasserts.

Structure
REQ-034 SHALL place the following in shared package shift_seq_pkg: state enum (IDLE, SHIFT, DONE), DIR_LEFT=0 / DIR_RIGHT=1 constants, and default WIDTH.
REQ-035 SHALL instantiate exactly one sub-module, shift_step: a WIDTH-bit register with ports load, en, dir, arith, d, q that shifts one bit per enabled edge.
REQ-036 SHALL keep the FSM, counter and handshake logic in shift_seq_ctrl; shift_step contains no control state.

Verification
REQ-037 SHALL cover: data 32'h7105c1a6, amt 12, dir left -> res_valid after edge k+12, res_data 32'h5c1a6000.
REQ-038 SHALL cover: data 32'h7105c1a6, amt 4, right, arith 0 -> res_data 32'h07105c1a; and data 32'h80000001, amt 4, right, arith 1 -> res_data 32'hf8000000.
REQ-039 SHALL cover: amt 0, data 32'hdeadbeef -> res_valid after edge k, res_data 32'hdeadbeef, busy for 1 cycle.
REQ-040 SHALL cover: res_ready held low 5 cycles in DONE -> res_valid and res_data stable throughout, req_ready=0; res_ready=1 -> IDLE next edge.
REQ-041 SHALL cover: amt 12, abort pulsed at the 3rd SHIFT cycle -> IDLE next edge, res_valid never asserted, next request processed correctly.
REQ-042 SHALL cover: clr pulsed low mid-SHIFT -> all outputs 0 immediately, req_ready=1 the cycle after release, no stale result.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the sequential (one bit per clock) shifter.
package shift_seq_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Operation mode latched at accept and held for the whole shift.
  typedef struct packed {
    logic dir;
    logic arith;
  } mode_t;

endpackage

// File: rtl/shift_step.sv
// WIDTH-bit datapath register: parallel load, or a one-bit shift per enabled edge.
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic             dir,
  input  logic             arith,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q, q_d;

  // Arithmetic fill re-copies the current MSB, which stays equal to the
  // captured sign bit across every step.
  always_comb begin
    q_d = q_q;
    if (load)
      q_d = d;
    else if (en) begin
      if (dir == DIR_LEFT)
        q_d = {q_q[WIDTH-2:0], 1'b0};
      else
        q_d = {arith & q_q[WIDTH-1], q_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Request/result handshake controller around a bit-serial shifter:
// one shift per clock, abortable, result held until consumed.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic [AMT_W-1:0] req_amt,
  input  logic             req_dir,
  input  logic             req_arith,
  input  logic             abort,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  mode_t            mode_q, mode_d;
  logic             accept;
  logic             shift_en;

  assign accept = req_valid && req_ready;

  // State register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // Next-state logic; abort wins over completion and over res_ready.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          mode_d.dir   = req_dir;
          mode_d.arith = req_arith;
          cnt_d        = req_amt;
          state_d      = (req_amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        if (abort || res_ready) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    req_ready = (state_q == IDLE) && clr;
    res_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    shift_en  = (state_q == SHIFT) && !abort;
  end

  shift_step #(.WIDTH(WIDTH)) u_step (
    .clk   (clk),
    .rst_n (clr),
    .load  (accept),
    .en    (shift_en),
    .dir   (mode_q.dir),
    .arith (mode_q.arith),
    .d     (req_data),
    .q     (res_data)
  );

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with hand-computed expectations.
module tb_shift_seq_ctrl;

  localparam int WIDTH = 32;
  localparam int AMT_W = 5;

  logic             clk = 1'b0;
  logic             clr;
  logic             req_valid, req_ready;
  logic [WIDTH-1:0] req_data;
  logic [AMT_W-1:0] req_amt;
  logic             req_dir, req_arith;
  logic             abort;
  logic             res_valid, res_ready;
  logic [WIDTH-1:0] res_data;
  logic             busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk       (clk),
    .clr       (clr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .req_dir   (req_dir),
    .req_arith (req_arith),
    .abort     (abort),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a request from IDLE; returns with the accepting edge k just passed.
  task automatic issue(input logic [31:0] d, input int amt, input logic dir, input logic ar);
    req_valid = 1'b1;
    req_data  = d;
    req_amt   = AMT_W'(amt);
    req_dir   = dir;
    req_arith = ar;
    tick();
    req_valid = 1'b0;
    req_data  = 32'h0;
  endtask

  // Wait (bounded) for res_valid; lat = edges after k.
  task automatic wait_res(output int lat);
    lat = 0;
    while (!res_valid && lat < 64) begin
      tick();
      lat++;
    end
  endtask

  task automatic take(input string tag);
    res_ready = 1'b1;
    chk({tag, "_rdy_in_take"}, {31'h0, req_ready}, 32'h0);
    tick();
    res_ready = 1'b0;
    chk({tag, "_vld_after"}, {31'h0, res_valid}, 32'h0);
    chk({tag, "_rdy_after"}, {31'h0, req_ready}, 32'h1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] d, input int amt,
                        input logic dir, input logic ar, input logic [31:0] exp);
    int lat;
    chk({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
    issue(d, amt, dir, ar);
    wait_res(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(amt));
    chk({tag, "_data"}, res_data, exp);
    take(tag);
  endtask

  initial begin
    int lat;
    req_valid = 0; req_data = 0; req_amt = 0; req_dir = 0; req_arith = 0;
    abort = 0; res_ready = 0;
    clr = 1'b1;
    #1 clr = 1'b0;
    #2;
    chk("rst_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_valid", {31'h0, res_valid}, 32'h0);
    chk("rst_busy",  {31'h0, busy},      32'h0);
    chk("rst_data",  res_data,           32'h0);
    tick();
    clr = 1'b1;
    #1;
    chk("rel_ready", {31'h0, req_ready}, 32'h1);

    run_op("l12",   32'h7105c1a6, 12, 1'b0, 1'b0, 32'h5c1a6000);
    run_op("r4log", 32'h7105c1a6, 4,  1'b1, 1'b0, 32'h07105c1a);
    run_op("r4ari", 32'h80000001, 4,  1'b1, 1'b1, 32'hf8000000);
    run_op("l31",   32'h00000001, 31, 1'b0, 1'b0, 32'h80000000);
    run_op("r31ar", 32'h80000000, 31, 1'b1, 1'b1, 32'hffffffff);
    run_op("r1log", 32'h80000001, 1,  1'b1, 1'b0, 32'h40000000);
    run_op("l1ari", 32'hc0000003, 1,  1'b0, 1'b1, 32'h80000006);

    // amt 0: result right after accept edge, busy for exactly one cycle
    issue(32'hdeadbeef, 0, 1'b0, 1'b0);
    chk("a0_vld",  {31'h0, res_valid}, 32'h1);
    chk("a0_busy", {31'h0, busy},      32'h1);
    chk("a0_data", res_data,           32'hdeadbeef);
    take("a0");
    chk("a0_idle", {31'h0, busy}, 32'h0);

    // Stall in DONE for 5 cycles
    issue(32'h0000000f, 4, 1'b0, 1'b0);
    wait_res(lat);
    chk("st_lat", 32'(lat), 32'd4);
    for (int i = 0; i < 5; i++) begin
      chk("st_vld",  {31'h0, res_valid}, 32'h1);
      chk("st_data", res_data,           32'h000000f0);
      chk("st_rdy",  {31'h0, req_ready}, 32'h0);
      tick();
    end
    take("st");

    // Abort on the 3rd SHIFT cycle
    issue(32'h7105c1a6, 12, 1'b0, 1'b0);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_busy", {31'h0, busy},      32'h0);
    chk("ab_rdy",  {31'h0, req_ready}, 32'h1);
    begin
      int seen = 0;
      for (int i = 0; i < 15; i++) begin
        if (res_valid) seen++;
        tick();
      end
      chk("ab_noresult", 32'(seen), 32'd0);
    end
    run_op("ab_next", 32'h7105c1a6, 4, 1'b1, 1'b0, 32'h07105c1a);

    // Abort in IDLE is ignored; request still accepted
    abort = 1'b1;
    issue(32'h12345678, 0, 1'b0, 1'b0);
    abort = 1'b0;
    chk("abi_vld",  {31'h0, res_valid}, 32'h1);
    chk("abi_data", res_data,           32'h12345678);
    // Abort beats res_ready in DONE
    abort = 1'b1;
    res_ready = 1'b1;
    tick();
    abort = 1'b0;
    res_ready = 1'b0;
    chk("abd_vld",  {31'h0, res_valid}, 32'h0);
    chk("abd_busy", {31'h0, busy},      32'h0);

    // clr pulsed mid-SHIFT
    issue(32'h7105c1a6, 12, 1'b0, 1'b0);
    tick();
    tick();
    clr = 1'b0;
    #1;
    chk("clr_vld",  {31'h0, res_valid}, 32'h0);
    chk("clr_busy", {31'h0, busy},      32'h0);
    chk("clr_rdy",  {31'h0, req_ready}, 32'h0);
    chk("clr_data", res_data,           32'h0);
    tick();
    clr = 1'b1;
    tick();
    chk("clr_rel_rdy", {31'h0, req_ready}, 32'h1);
    begin
      int seen = 0;
      for (int i = 0; i < 15; i++) begin
        if (res_valid || busy) seen++;
        tick();
      end
      chk("clr_nostale", 32'(seen), 32'd0);
    end
    run_op("clr_next", 32'h80000001, 4, 1'b1, 1'b1, 32'hf8000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
